hdmi_period_sched: RTL
======================

# hdmi_period_sched

Per-pixel scheduler that converts the DVI-style timing stream into HDMI period sequencing for the TMDS encoder/serializer datapath. Each pixel clock it selects one of: control, video preamble, video guard band, active video, data-island preamble, island guard bands, or island data. It also arbitrates one data-island slot per line to an upstream packet source. It sits between the x/y timing counters and the per-channel TMDS word mux feeding the OSER10 serializers.

## Interface
Parameters:
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines
- ISLAND_START, 644, x at which a granted island's preamble begins
- ISLAND_PKT_MAX, 2, maximum packets per island (32 data cycles each)

Ports:
- pxl_clk  in  1  pixel clock; the only clock
- rst_n  in  1  reset; synchronous, active-low
- x  in  10  current pixel column, 0..FRAME_WIDTH-1
- y  in  10  current line, 0..FRAME_HEIGHT-1
- hsync_in, vsync_in  in  1 each  sync levels for the current x/y
- island_req  in  1  packet source requests an island
- island_npkt  in  2  packets requested, sampled at grant
- island_gnt  out  1  one-cycle grant pulse
- period  out  3  period code (package enum)
- ctl  out  4  CTL0..CTL3 for channels 1/2 control words
- hsync, vsync  out  1 each  sync, aligned to period
- island_pkt  out  1  packet index within island
- island_beat  out  5  data beat 0..31 within packet

## Operation
- All outputs are registered from the current x/y and reflect them one cycle later.
- next_active = ((y+1) mod FRAME_HEIGHT) < SCREEN_HEIGHT. cur_active = y < SCREEN_HEIGHT.
- Video priority, evaluated per x:
  - VIDEO when cur_active and x < SCREEN_WIDTH.
  - VID_PRE when next_active and FRAME_WIDTH-10 ≤ x ≤ FRAME_WIDTH-3. ctl = 4'b0001 (CTL0=1).
  - VID_GB when next_active and x ≥ FRAME_WIDTH-2.
- Otherwise the island FSM owns the period. The FSM is IDLE → DI_PRE(8) → DI_LGB(2) → DATA(32·n) → DI_TGB(2) → IDLE.
  - At x == ISLAND_START-1 in IDLE, with island_req=1 and island_npkt≠0: latch n = min(island_npkt, ISLAND_PKT_MAX).
  - island_gnt pulses in the same output cycle as the first DI_PRE.
  - DI_PRE drives ctl = 4'b0101 (CTL0=CTL2=1).
  - island_beat counts 0..31 and wraps. island_pkt increments on each wrap.
- Any remaining cycle is CTRL with ctl = 0.
- At most one island per line. Islands are allowed in every line, including vertical blanking.
- With defaults, an island occupies x 644..719 (12+64 cycles). This leaves ≥4 control cycles after video and ≥66 before VID_PRE.
- island_req must be held until island_gnt. The source deasserts it after the grant; a req still high is considered again on the next line.
- island_npkt == 0 is treated as no request. Values above ISLAND_PKT_MAX are clamped.
- hsync/vsync are hsync_in/vsync_in delayed one cycle, in every period.

## Timing
- Latency: x/y/sync to outputs = 1 pxl_clk.
- Reset values: period=CTRL, ctl=0, hsync=vsync=1, island_gnt=0, island_pkt=0, island_beat=0, FSM=IDLE.
- Reset asserted mid-island: island aborted at the next edge; grant is not re-issued. The first new grant opportunity is the next ISLAND_START-1 after rst_n returns high.
- A grant and VID_PRE never overlap under legal parameters. If parameters would overlap them, video wins and the FSM is forced to IDLE.
- x/y wrap (799→0, 524→0) needs no special case beyond the next_active modulo.

## Structure
- Shared package hdmi_pkg holds:
  - period enum: CTRL, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_LGB, DATA, DI_TGB
  - preamble ctl constants
  - guard-band words 10'b1011001100 and 10'b0100110011
  - the four control-period TMDS words, which the TMDS word mux also uses
- One sub-module, hdmi_island_seq, holds the island FSM and the beat/packet counters. The top level does the video-priority decode and the output registers.

## Test plan
- Reset, then free-run a full frame with no requests → line 0 shows period VIDEO for exactly 640 cycles. y=479 shows no VID_PRE/VID_GB. y=524 shows VID_PRE at x 790..797 and VID_GB at x 798..799, one cycle delayed.
- island_req=1, npkt=2 held from x=600 → gnt pulses once, at output cycle for x=644. DI_PRE x644..651, DI_LGB 652..653, DATA 654..717 with pkt 0→1 at beat wrap, DI_TGB 718..719.
- npkt=3 → clamped: DATA lasts 64 cycles. npkt=0 → no grant, all-CTRL blanking.
- req held across two lines → exactly one island per line, one gnt per line.
- rst_n low at x=670 of an island → next output CTRL, no gnt. The island resumes only on the following line.
- Request during vertical blanking (y=500) → island is granted. ctl=4'b0101 in DI_PRE. vsync follows vsync_in delayed by 1.

Source files
------------

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared HDMI period codes, preamble controls and TMDS fixed words.
package hdmi_pkg;
  typedef enum logic [2:0] {
    CTRL,
    VID_PRE,
    VID_GB,
    VIDEO,
    DI_PRE,
    DI_LGB,
    DATA,
    DI_TGB
  } period_t;
  typedef enum logic [2:0] {
    ISL_IDLE,
    ISL_PRE,
    ISL_LGB,
    ISL_DATA,
    ISL_TGB
  } isl_state_t;
  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_DI_PRE  = 4'b0101;
  localparam logic [9:0] GB_WORD_A = 10'b1011001100;
  localparam logic [9:0] GB_WORD_B = 10'b0100110011;
  localparam logic [9:0] CTRL_WORD_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_WORD_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_WORD_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_WORD_11 = 10'b1010101011;
  function automatic logic [9:0] ctrl_word(input logic [1:0] c);
    return c == 2'b00 ? CTRL_WORD_00 : c == 2'b01 ? CTRL_WORD_01 :
           c == 2'b10 ? CTRL_WORD_10 : CTRL_WORD_11;
  endfunction
endpackage

// File: rtl/hdmi_period_sched_if.sv
// hdmi_period_sched_if: timing-in, island handshake and period-out bundle.
interface hdmi_period_sched_if;
  import hdmi_pkg::*;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync_in;
  logic       vsync_in;
  logic       island_req;
  logic [1:0] island_npkt;
  logic       island_gnt;
  period_t    period;
  logic [3:0] ctl;
  logic       hsync;
  logic       vsync;
  logic       island_pkt;
  logic [4:0] island_beat;
  modport master (
    output x, y, hsync_in, vsync_in, island_req, island_npkt,
    input  island_gnt, period, ctl, hsync, vsync, island_pkt, island_beat
  );
  modport slave (
    input  x, y, hsync_in, vsync_in, island_req, island_npkt,
    output island_gnt, period, ctl, hsync, vsync, island_pkt, island_beat
  );
endinterface

// File: rtl/hdmi_island_seq.sv
// hdmi_island_seq: per-line data-island FSM with beat and packet counters.
module hdmi_island_seq
  import hdmi_pkg::*;
#(
  parameter int ISLAND_START   = 644,
  parameter int ISLAND_PKT_MAX = 2
) (
  input  logic       pxl_clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic       req,
  input  logic [1:0] npkt,
  input  logic       force_idle,
  output period_t    period,
  output logic       gnt,
  output logic       pkt,
  output logic [4:0] beat
);
  localparam logic [9:0] GO_X = 10'(ISLAND_START - 1);
  localparam logic [1:0] PMAX = 2'(ISLAND_PKT_MAX);
  isl_state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt;
  logic       idx, idx_nxt;
  logic [1:0] n, n_nxt;
  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      state <= ISL_IDLE;
      cnt   <= '0;
      idx   <= 1'b0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      n     <= n_nxt;
    end
  end
  // cnt doubles as the preamble/guard-band position and as the data beat
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 5'd1;
    idx_nxt   = idx;
    n_nxt     = n;
    case (state)
      ISL_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = 1'b0;
        if (x == GO_X && req && npkt != 2'd0) begin
          state_nxt = ISL_PRE;
          n_nxt     = npkt > PMAX ? PMAX : npkt;
        end
      end
      ISL_PRE: if (cnt == 5'd7) begin
        state_nxt = ISL_LGB;
        cnt_nxt   = '0;
      end
      ISL_LGB: if (cnt == 5'd1) begin
        state_nxt = ISL_DATA;
        cnt_nxt   = '0;
      end
      ISL_DATA: if (cnt == 5'd31) begin
        idx_nxt = idx + 1'b1;
        if ({1'b0, idx} == n - 2'd1) begin
          state_nxt = ISL_TGB;
          idx_nxt   = 1'b0;
        end
      end
      ISL_TGB: if (cnt == 5'd1) begin
        state_nxt = ISL_IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = ISL_IDLE;
    endcase
    if (force_idle) begin
      state_nxt = ISL_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = 1'b0;
    end
  end
  always_comb begin
    period = state == ISL_PRE  ? DI_PRE :
             state == ISL_LGB  ? DI_LGB :
             state == ISL_DATA ? DATA   :
             state == ISL_TGB  ? DI_TGB : CTRL;
    gnt  = state == ISL_PRE && cnt == '0;
    beat = state == ISL_DATA ? cnt : '0;
    pkt  = state == ISL_DATA && idx;
  end
endmodule

// File: rtl/hdmi_period_sched.sv
// hdmi_period_sched: per-pixel HDMI period scheduler with one data island per line.
module hdmi_period_sched
  import hdmi_pkg::*;
#(
  parameter int FRAME_WIDTH    = 800,
  parameter int FRAME_HEIGHT   = 525,
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int ISLAND_START   = 644,
  parameter int ISLAND_PKT_MAX = 2
) (
  input logic               pxl_clk,
  input logic               rst_n,
  hdmi_period_sched_if.slave bus
);
  localparam logic [9:0] FH_LAST = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] SW      = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SH      = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] VP_LO   = 10'(FRAME_WIDTH - 10);
  localparam logic [9:0] VP_HI   = 10'(FRAME_WIDTH - 3);
  localparam logic [9:0] VG_LO   = 10'(FRAME_WIDTH - 2);
  logic [9:0] y_nxt;
  logic       cur_active, next_active, video;
  logic       isl_gnt, isl_pkt;
  logic [4:0] isl_beat;
  period_t    vid_per, isl_per, per;
  always_comb begin
    y_nxt       = bus.y == FH_LAST ? '0 : bus.y + 10'd1;
    cur_active  = bus.y < SH;
    next_active = y_nxt < SH;
    vid_per = cur_active && bus.x < SW ? VIDEO :
              next_active && bus.x >= VP_LO && bus.x <= VP_HI ? VID_PRE :
              next_active && bus.x >= VG_LO ? VID_GB : CTRL;
    video = vid_per != CTRL;
    per   = video ? vid_per : isl_per;
  end
  // video always outranks the island; the FSM is dropped back to idle on overlap
  hdmi_island_seq #(
    .ISLAND_START  (ISLAND_START),
    .ISLAND_PKT_MAX(ISLAND_PKT_MAX)
  ) u_seq (
    .pxl_clk   (pxl_clk),
    .rst_n     (rst_n),
    .x         (bus.x),
    .req       (bus.island_req),
    .npkt      (bus.island_npkt),
    .force_idle(video),
    .period    (isl_per),
    .gnt       (isl_gnt),
    .pkt       (isl_pkt),
    .beat      (isl_beat)
  );
  always_ff @(posedge pxl_clk) begin
    if (!rst_n) begin
      bus.period      <= CTRL;
      bus.ctl         <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.island_gnt  <= 1'b0;
      bus.island_pkt  <= 1'b0;
      bus.island_beat <= '0;
    end else begin
      bus.period      <= per;
      bus.ctl         <= per == VID_PRE ? CTL_VID_PRE : per == DI_PRE ? CTL_DI_PRE : 4'b0000;
      bus.hsync       <= bus.hsync_in;
      bus.vsync       <= bus.vsync_in;
      bus.island_gnt  <= isl_gnt && !video;
      bus.island_pkt  <= isl_pkt && !video;
      bus.island_beat <= video ? 5'd0 : isl_beat;
    end
  end
endmodule
